// File: rtl/sram_banked_wq_if.sv
// Lane bus for the banked write-queued SRAM.
// Master drives address/write requests; slave returns ready, read data and status.
interface sram_banked_wq_if #(
   parameter int NLANE = 4,
   parameter int WORDS = 16384,
   parameter int DW    = 32
);
   localparam int AW = $clog2(WORDS);

   logic [NLANE*AW-1:0] addr;
   logic [NLANE-1:0]    we;
   logic [NLANE*DW-1:0] wd;
   logic [NLANE-1:0]    wready;
   logic [NLANE*DW-1:0] rd;
   logic                idle;
   logic [NLANE-1:0]    ovf;

   modport master (
      output addr, we, wd,
      input  wready, rd, idle, ovf
   );

   modport slave (
      input  addr, we, wd,
      output wready, rd, idle, ovf
   );
endinterface

// File: rtl/sram_banked_wq.sv
// Multi-lane banked SRAM: per-lane write queues drain into interleaved
// banks through per-bank round-robin arbiters; reads see committed data only.
module sram_banked_wq #(
   parameter int NLANE = 4,
   parameter int NBANK = 4,
   parameter int WORDS = 16384,
   parameter int DW    = 32,
   parameter int QAW   = 8
)(
   input logic              clk,
   input logic              rstn,
   sram_banked_wq_if.slave  bus
);
   localparam int AW     = $clog2(WORDS);
   localparam int LOGB   = $clog2(NBANK);
   localparam int IW     = (AW > LOGB) ? AW - LOGB : 1;
   localparam int BSW    = (LOGB > 0) ? LOGB : 1;
   localparam int LW     = (NLANE > 1) ? $clog2(NLANE) : 1;
   localparam int QD     = 1 << QAW;
   localparam int CW     = QAW + 1;
   localparam int BDEPTH = WORDS / NBANK;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   function automatic logic [BSW-1:0] bank_of(logic [AW-1:0] a);
      return BSW'(a % AW'(NBANK));
   endfunction

   function automatic logic [IW-1:0] idx_of(logic [AW-1:0] a);
      return IW'(a / AW'(NBANK));
   endfunction

   ent_t           q_mem [NLANE][QD];
   logic [DW-1:0]  mem   [NBANK][BDEPTH];

   logic [QAW-1:0] wp_q  [NLANE];
   logic [QAW-1:0] rp_q  [NLANE];
   logic [CW-1:0]  cnt_q [NLANE];
   logic [LW-1:0]  rr_q  [NBANK];
   logic [NLANE-1:0] ovf_q;

   logic [NLANE-1:0] wready;
   logic [NLANE-1:0] push;
   logic [NLANE-1:0] pop;
   logic             idle;
   ent_t             head  [NLANE];
   logic [BSW-1:0]   hbank [NLANE];
   logic [NBANK-1:0] gnt_v;
   logic [LW-1:0]    gnt_l [NBANK];
   logic [NLANE*DW-1:0] rd_w;

   // Queue status depends only on registered counts.
   always_comb begin
      idle = 1'b1;
      for (int i = 0; i < NLANE; i++) begin
         wready[i] = cnt_q[i] != CW'(QD);
         push[i]   = bus.we[i] & wready[i];
         head[i]   = q_mem[i][rp_q[i]];
         hbank[i]  = bank_of(head[i].a);
         if (cnt_q[i] != '0) idle = 1'b0;
      end
   end

   always_comb begin
      int l;
      l     = 0;
      pop   = '0;
      gnt_v = '0;
      for (int b = 0; b < NBANK; b++) begin
         gnt_l[b] = '0;
         for (int k = 0; k < NLANE; k++) begin
            l = int'(rr_q[b]) + k;
            if (l >= NLANE) l = l - NLANE;
            if (!gnt_v[b] && cnt_q[l] != '0 &&
                int'(hbank[l]) == b) begin
               gnt_v[b] = 1'b1;
               gnt_l[b] = LW'(l);
            end
         end
         if (gnt_v[b]) pop[gnt_l[b]] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NLANE; i++) begin
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         for (int b = 0; b < NBANK; b++) rr_q[b] <= '0;
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NLANE; i++) begin
            if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
            if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
            cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         end
         for (int b = 0; b < NBANK; b++) begin
            if (gnt_v[b])
               rr_q[b] <= (int'(gnt_l[b]) == NLANE - 1) ?
                          '0 : gnt_l[b] + 1'b1;
         end
         ovf_q <= ovf_q | (bus.we & ~wready);
      end
   end

   // Storage arrays carry no reset; validity lives in the counters.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NLANE; i++) begin
         if (push[i])
            q_mem[i][wp_q[i]] <= '{a: bus.addr[i*AW +: AW],
                                   d: bus.wd[i*DW +: DW]};
      end
      for (int b = 0; b < NBANK; b++) begin
         if (gnt_v[b])
            mem[b][idx_of(head[gnt_l[b]].a)] <= head[gnt_l[b]].d;
      end
   end

   always_comb begin
      logic [AW-1:0] a;
      a    = '0;
      rd_w = '0;
      for (int i = 0; i < NLANE; i++) begin
         a = bus.addr[i*AW +: AW];
         rd_w[i*DW +: DW] = mem[bank_of(a)][idx_of(a)];
      end
   end

   assign bus.wready = wready;
   assign bus.rd     = rd_w;
   assign bus.idle   = idle;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_sram_banked_wq.sv
// Bench for sram_banked_wq: directed scenarios plus random traffic
// checked against a queue-level reference model.
module tb_sram_banked_wq;
   localparam int NL    = 4;
   localparam int NB    = 4;
   localparam int WORDS = 16384;
   localparam int DW    = 32;
   localparam int QAW   = 8;
   localparam int AW    = $clog2(WORDS);
   localparam int QD    = 1 << QAW;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   sram_banked_wq_if #(.NLANE(NL), .WORDS(WORDS), .DW(DW)) bus();

   sram_banked_wq #(
      .NLANE(NL), .NBANK(NB), .WORDS(WORDS), .DW(DW), .QAW(QAW)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [AW-1:0] t_addr [NL];
   logic [DW-1:0] t_wd   [NL];
   logic [NL-1:0] t_we;

   for (genvar g = 0; g < NL; g++) begin : g_drv
      assign bus.addr[g*AW +: AW] = t_addr[g];
      assign bus.wd[g*DW +: DW]   = t_wd[g];
   end
   assign bus.we = t_we;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: per-lane FIFOs, flat word memory, per-bank RR pointer.
   typedef struct {
      int          a;
      logic [31:0] d;
   } ment_t;

   ment_t       mq [NL][$];
   logic [31:0] mm [int];
   int          mrr [NB];
   logic [NL-1:0] movf;

   task automatic model_reset();
      for (int i = 0; i < NL; i++) mq[i].delete();
      for (int b = 0; b < NB; b++) mrr[b] = 0;
      movf = '0;
   endtask

   task automatic model_edge();
      bit    full [NL];
      int    win  [NB];
      int    l;
      ment_t e;
      if (!rstn) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NL; i++) full[i] = mq[i].size() >= QD;
      for (int b = 0; b < NB; b++) begin
         win[b] = -1;
         for (int k = 0; k < NL; k++) begin
            l = (mrr[b] + k) % NL;
            if (win[b] < 0 && mq[l].size() > 0 && mq[l][0].a % NB == b)
               win[b] = l;
         end
      end
      for (int b = 0; b < NB; b++) begin
         if (win[b] >= 0) begin
            e = mq[win[b]].pop_front();
            mm[e.a] = e.d;
            mrr[b] = (win[b] + 1) % NL;
         end
      end
      for (int i = 0; i < NL; i++) begin
         if (t_we[i]) begin
            if (full[i]) movf[i] = 1'b1;
            else mq[i].push_back('{a: int'(t_addr[i]), d: t_wd[i]});
         end
      end
   endtask

   function automatic logic [NL-1:0] exp_wready();
      logic [NL-1:0] w;
      for (int i = 0; i < NL; i++) w[i] = mq[i].size() < QD;
      return w;
   endfunction

   function automatic logic exp_idle();
      for (int i = 0; i < NL; i++) if (mq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [DW-1:0] rdl(int i);
      return bus.rd[i*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drain(int bound);
      for (int n = 0; n < bound && !exp_idle(); n++) tick();
      tick();
   endtask

   task automatic test_reset();
      #2;
      n_chk++;
      if (bus.wready !== 4'hF) begin
         n_err++;
         $display("FAIL reset_wready: got %b want 1111", bus.wready);
      end
      n_chk++;
      if (bus.idle !== 1'b1) begin
         n_err++;
         $display("FAIL reset_idle: got %b want 1", bus.idle);
      end
      n_chk++;
      if (bus.ovf !== 4'h0) begin
         n_err++;
         $display("FAIL reset_ovf: got %b want 0000", bus.ovf);
      end
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_single();
      t_addr[0] = AW'(5);
      t_wd[0]   = 32'hDEADBEEF;
      t_we      = 4'b0001;
      tick();
      t_we = '0;
      n_chk++;
      if (bus.idle !== 1'b0) begin
         n_err++;
         $display("FAIL single_idle_busy: got %b want 0", bus.idle);
      end
      tick();
      n_chk++;
      if (rdl(0) !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL single_rd: got %h want deadbeef", rdl(0));
      end
      n_chk++;
      if (bus.idle !== 1'b1) begin
         n_err++;
         $display("FAIL single_idle_done: got %b want 1", bus.idle);
      end
   endtask

   task automatic test_distinct_banks();
      for (int i = 0; i < NL; i++) begin
         t_addr[i] = AW'(i);
         t_wd[i]   = 32'hA0000000 | 32'(i);
      end
      t_we = 4'hF;
      tick();
      t_we = '0;
      tick();
      for (int i = 0; i < NL; i++) begin
         n_chk++;
         if (rdl(i) !== (32'hA0000000 | 32'(i))) begin
            n_err++;
            $display("FAIL distinct_rd lane%0d: got %h want %h",
                     i, rdl(i), 32'hA0000000 | 32'(i));
         end
      end
      n_chk++;
      if (bus.idle !== 1'b1) begin
         n_err++;
         $display("FAIL distinct_idle: got %b want 1", bus.idle);
      end
      for (int c = 1; c < 4; c++) begin
         for (int i = 0; i < NL; i++) begin
            t_addr[i] = AW'(4 * c + i);
            t_wd[i]   = 32'hA0000000 | 32'(4 * c + i);
         end
         t_we = 4'hF;
         tick();
         t_we = '0;
      end
      drain(20);
   endtask

   task automatic test_same_bank();
      logic [31:0] oldv [NL];
      logic [31:0] newv [NL];
      logic [31:0] expv;
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      model_reset();
      for (int j = 0; j < NL; j++) oldv[j] = 32'hA0000000 | 32'(1 + 4 * j);
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < NL; i++) begin
            t_addr[i] = AW'(1 + 4 * i);
            newv[i]   = (rep == 0 ? 32'hB0000000 : 32'hC0000000) | 32'(i);
            t_wd[i]   = newv[i];
         end
         t_we = 4'hF;
         tick();
         t_we = '0;
         for (int k = 1; k <= NL; k++) begin
            tick();
            for (int j = 0; j < NL; j++) begin
               expv = (j < k) ? newv[j] : oldv[j];
               n_chk++;
               if (rdl(j) !== expv) begin
                  n_err++;
                  $display("FAIL same_bank rep%0d edge%0d lane%0d: got %h want %h",
                           rep, k, j, rdl(j), expv);
               end
            end
         end
         for (int j = 0; j < NL; j++) oldv[j] = newv[j];
      end
   endtask

   task automatic test_same_addr();
      t_addr[1] = AW'(32);
      t_wd[1]   = 32'h00000020;
      t_we      = 4'b0010;
      tick();
      t_we = '0;
      tick();
      t_addr[1] = AW'(16);
      t_addr[3] = AW'(16);
      t_wd[1]   = 32'h11;
      t_wd[3]   = 32'h33;
      t_we      = 4'b1010;
      tick();
      t_we = '0;
      tick();
      n_chk++;
      if (rdl(1) !== 32'h33) begin
         n_err++;
         $display("FAIL same_addr_first: got %h want 00000033", rdl(1));
      end
      tick();
      n_chk++;
      if (rdl(3) !== 32'h11) begin
         n_err++;
         $display("FAIL same_addr_final: got %h want 00000011", rdl(3));
      end
   endtask

   task automatic test_overflow();
      int k2;
      int n;
      k2 = 0;
      n  = 0;
      t_addr[1] = AW'(16'h3000);
      t_wd[1]   = 32'h0C0FFEE0;
      t_we      = 4'b0010;
      tick();
      t_we = '0;
      drain(10);
      while (mq[2].size() < QD && n < 1500) begin
         t_we      = '0;
         t_addr[2] = AW'(256 + 4 * (k2 % 64));
         t_wd[2]   = $urandom;
         t_we[2]   = 1'b1;
         k2++;
         if (mq[0].size() < QD) begin
            t_addr[0] = AW'(8192 + 4 * (n % 64));
            t_wd[0]   = $urandom;
            t_we[0]   = 1'b1;
         end
         tick();
         n++;
         n_chk++;
         if (bus.wready !== exp_wready()) begin
            n_err++;
            $display("FAIL ovf_fill_wready cyc%0d: got %b want %b",
                     n, bus.wready, exp_wready());
         end
      end
      t_we = '0;
      n_chk++;
      if (bus.wready[2] !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_full_wready: got %b want 0", bus.wready[2]);
      end
      t_addr[2] = AW'(16'h3000);
      t_wd[2]   = 32'hBAD0BAD0;
      t_we      = 4'b0100;
      tick();
      t_we = '0;
      n_chk++;
      if (bus.ovf !== 4'b0100) begin
         n_err++;
         $display("FAIL ovf_sticky: got %b want 0100", bus.ovf);
      end
      drain(1500);
      n_chk++;
      if (bus.idle !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_drain_idle: got %b want 1", bus.idle);
      end
      n_chk++;
      if (rdl(1) !== 32'h0C0FFEE0) begin
         n_err++;
         $display("FAIL ovf_lost_write: got %h want 0c0ffee0", rdl(1));
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NL; i++) begin
            t_addr[i] = AW'($urandom_range(0, 63));
            t_wd[i]   = $urandom;
         end
         t_we = NL'($urandom);
         tick();
         t_we = '0;
         n_chk++;
         if (bus.wready !== exp_wready() || bus.idle !== exp_idle() ||
             bus.ovf !== movf) begin
            n_err++;
            $display("FAIL rand_status cyc%0d: got %b/%b/%b want %b/%b/%b", c,
                     bus.wready, bus.idle, bus.ovf,
                     exp_wready(), exp_idle(), movf);
         end
         for (int i = 0; i < NL; i++) begin
            if (mm.exists(int'(t_addr[i]))) begin
               n_chk++;
               if (rdl(i) !== mm[int'(t_addr[i])]) begin
                  n_err++;
                  $display("FAIL rand_rd cyc%0d lane%0d: got %h want %h",
                           c, i, rdl(i), mm[int'(t_addr[i])]);
               end
            end
         end
      end
      drain(100);
   endtask

   task automatic test_reset_mid();
      int a;
      int nnew;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NL; i++) begin
            a = 1024 + 4 * (4 * c + i);
            t_addr[i] = AW'(a);
            t_wd[i]   = 32'h50000000 | 32'(a);
         end
         t_we = 4'hF;
         tick();
         t_we = '0;
      end
      drain(40);
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < NL; i++) begin
            a = 1024 + 4 * (4 * c + i);
            t_addr[i] = AW'(a);
            t_wd[i]   = 32'h60000000 | 32'(a);
         end
         t_we = 4'hF;
         tick();
      end
      t_we = '0;
      rstn = 1'b0;
      #1;
      model_reset();
      n_chk++;
      if (bus.wready !== 4'hF || bus.idle !== 1'b1 || bus.ovf !== 4'h0) begin
         n_err++;
         $display("FAIL midreset_async: got %b/%b/%b want 1111/1/0000",
                  bus.wready, bus.idle, bus.ovf);
      end
      tick();
      tick();
      rstn = 1'b1;
      tick();
      tick();
      nnew = 0;
      for (int k = 0; k < 12; k++) begin
         a = 1024 + 4 * k;
         t_addr[0] = AW'(a);
         #1;
         if (rdl(0)[31:28] == 4'h6) nnew++;
         n_chk++;
         if (rdl(0) !== mm[a]) begin
            n_err++;
            $display("FAIL midreset_rd addr%0d: got %h want %h",
                     a, rdl(0), mm[a]);
         end
      end
      n_chk++;
      if (nnew != 2) begin
         n_err++;
         $display("FAIL midreset_commits: got %0d want 2", nnew);
      end
   endtask

   initial begin
      t_we = '0;
      for (int i = 0; i < NL; i++) begin
         t_addr[i] = '0;
         t_wd[i]   = '0;
      end
      model_reset();
      test_reset();
      test_single();
      test_distinct_banks();
      test_same_bank();
      test_same_addr();
      test_overflow();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end
endmodule
